// File: rtl/regfile_sb_pkg.sv
// Shared register-file defaults so decode and writeback agree on widths.
package regfile_sb_pkg;

    localparam int unsigned RF_DATA_W   = 16;
    localparam int unsigned RF_NUM_REGS = 16;
    localparam int unsigned RF_ADDR_W   = $clog2(RF_NUM_REGS);
    localparam bit          RF_ZERO_REG = 1'b1;

    // True when addr names the hardwired zero register.
    function automatic bit rf_is_zero(input bit zero_reg, input int unsigned addr);
        return zero_reg && (addr == 0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: busy bits, issue handshake and busy-register count.
module rf_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter bit          ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic              issue_ready,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam logic [ADDR_W:0] CntOne = (ADDR_W + 1)'(1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                issue_zero, wr_zero, set_hit, clr_hit, inc, dec;

    assign issue_zero = rf_is_zero(ZERO_REG, int'(issue_addr));
    assign wr_zero    = rf_is_zero(ZERO_REG, int'(wr_addr));

    // A busy destination stalls issue unless this cycle's writeback retires it.
    assign issue_ready = issue_zero | ~busy_q[issue_addr] | (wr_en & (wr_addr == issue_addr));

    assign set_hit = issue_valid & issue_ready & ~issue_zero;
    assign clr_hit = wr_en & ~wr_zero;
    assign inc     = set_hit & ~busy_q[issue_addr];
    // A write to the register being re-reserved leaves it busy, so no decrement.
    assign dec     = clr_hit & busy_q[wr_addr] & ~(set_hit & (issue_addr == wr_addr));

    // Next busy vector and count; the new reservation wins over a same-register clear.
    always_comb begin
        busy_d = busy_q;
        if (clr_hit) busy_d[wr_addr] = 1'b0;
        if (set_hit) busy_d[issue_addr] = 1'b1;
        cnt_d = cnt_q;
        if (inc && !dec) cnt_d = cnt_q + CntOne;
        else if (dec && !inc) cnt_d = cnt_q - CntOne;
    end

    // Scoreboard state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy        = busy_q;
    assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through bypass and integrated write scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int unsigned DATA_W   = RF_DATA_W,
    parameter int unsigned NUM_REGS = RF_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = RF_ZERO_REG,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    output logic [ADDR_W:0]          pending_cnt
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_zero;

    assign wr_zero = rf_is_zero(ZERO_REG, int'(wr_addr));

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy        (busy),
        .issue_ready (issue_ready),
        .pending_cnt (pending_cnt)
    );

    // Storage: reset clears everything, writes to the zero register are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (wr_en && !wr_zero) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              is_zero;
        assign addr    = rd_addr[i*ADDR_W +: ADDR_W];
        assign is_zero = rf_is_zero(ZERO_REG, int'(addr));

        // Read mux: zero register, then same-cycle writeback bypass, then storage.
        always_comb begin
            rd_data[i*DATA_W +: DATA_W] = regs_q[addr];
            rd_busy[i]                  = busy[addr];
            if (is_zero) begin
                rd_data[i*DATA_W +: DATA_W] = '0;
                rd_busy[i]                  = 1'b0;
            end else if (wr_en && (wr_addr == addr)) begin
                rd_data[i*DATA_W +: DATA_W] = wr_data;
                rd_busy[i]                  = 1'b0;
            end
        end
    end

endmodule
